// File: rtl/ac_pkg.sv
// ---------------------------------------------------------------------------
// ac_pkg
// Shared types and helpers for the multi-zone air-conditioning controller.
//   zone_state_e : per-zone FSM state (IDLE/COOL/HEAT/WAIT)
//   MODE_*       : global mode select codes (bit0 = heat enable, bit1 = cool)
//   cnt_width()  : width of the shared run/lockout counter
// ---------------------------------------------------------------------------
package ac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_COOL = 2'b01,
    ST_HEAT = 2'b10,
    ST_WAIT = 2'b11
  } zone_state_e;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_HEAT = 2'b01;
  localparam logic [1:0] MODE_COOL = 2'b10;
  localparam logic [1:0] MODE_AUTO = 2'b11;

  // One counter serves both the minimum-run and the lockout phases, so it
  // must hold the larger of the two terminal values; never narrower than 1.
  function automatic int cnt_width(input int min_on, input int min_off);
    int m;
    int w;
    m = (min_on > min_off) ? min_on : min_off;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ac_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// ac_ctrl_multi_if
// Sensor/drive bundle of the multi-zone controller.
//   mode       : global mode select (00 off, 01 heat, 10 cool, 11 auto)
//   temp       : packed zone temperatures, zone i at [i*TEMP_W +: TEMP_W]
//   heating    : heater drive per zone
//   cooling    : cooler drive per zone
//   lockout    : zone in post-run lockout
//   any_active : OR of all heating and cooling bits
// master = sensor/plant side, slave = controller.
// ---------------------------------------------------------------------------
interface ac_ctrl_multi_if #(
  parameter int NUM_ZONES = 4,
  parameter int TEMP_W    = 5
);
  logic [1:0]                  mode;
  logic [NUM_ZONES*TEMP_W-1:0] temp;
  logic [NUM_ZONES-1:0]        heating;
  logic [NUM_ZONES-1:0]        cooling;
  logic [NUM_ZONES-1:0]        lockout;
  logic                        any_active;

  modport master (
    output mode, temp,
    input  heating, cooling, lockout, any_active
  );

  modport slave (
    input  mode, temp,
    output heating, cooling, lockout, any_active
  );
endinterface

// File: rtl/ac_zone.sv
// ---------------------------------------------------------------------------
// ac_zone
// One zone's heat/cool FSM with hysteresis, minimum run time and post-run
// lockout. Outputs are Moore decodes of the registered state.
//   clk, rst    : clock, asynchronous active-high reset
//   i_heat_en   : heating permitted by global mode
//   i_cool_en   : cooling permitted by global mode
//   i_temp      : zone temperature, unsigned whole degrees
//   o_heating   : state == HEAT
//   o_cooling   : state == COOL
//   o_lockout   : state == WAIT
// ---------------------------------------------------------------------------
module ac_zone
  import ac_pkg::*;
#(
  parameter int TEMP_W   = 5,
  parameter int COOL_ON  = 22,
  parameter int COOL_OFF = 20,
  parameter int HEAT_ON  = 18,
  parameter int HEAT_OFF = 20,
  parameter int MIN_ON   = 4,
  parameter int MIN_OFF  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_heat_en,
  input  logic              i_cool_en,
  input  logic [TEMP_W-1:0] i_temp,
  output logic              o_heating,
  output logic              o_cooling,
  output logic              o_lockout
);

  localparam int CNT_W = cnt_width(MIN_ON, MIN_OFF);

  localparam logic [TEMP_W-1:0] TH_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] TH_COOL_OFF = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] TH_HEAT_ON  = TEMP_W'(HEAT_ON);
  localparam logic [TEMP_W-1:0] TH_HEAT_OFF = TEMP_W'(HEAT_OFF);

  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // With no lockout configured a finished run returns straight to IDLE.
  localparam zone_state_e ST_END = (MIN_OFF == 0) ? ST_IDLE : ST_WAIT;

  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) && (COOL_OFF < COOL_ON) &&
        (COOL_ON < (1 << TEMP_W)) && (HEAT_ON >= 0) && (MIN_ON >= 1) && (MIN_OFF >= 0)))
  begin : g_bad_cfg
    $error("ac_zone: illegal threshold / timing configuration");
  end

  zone_state_e      r_state;
  zone_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (i_cool_en && (i_temp >= TH_COOL_ON)) begin
          w_state_nxt = ST_COOL;
        end else if (i_heat_en && (i_temp <= TH_HEAT_ON)) begin
          w_state_nxt = ST_HEAT;
        end
      end
      ST_COOL: begin
        // Mode withdrawal aborts at once; a temperature exit waits for MIN_ON.
        if (!i_cool_en || ((i_temp <= TH_COOL_OFF) && (r_cnt == ON_LAST))) begin
          w_state_nxt = ST_END;
          w_cnt_nxt   = '0;
        end else if (r_cnt != ON_LAST) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_HEAT: begin
        if (!i_heat_en || ((i_temp >= TH_HEAT_OFF) && (r_cnt == ON_LAST))) begin
          w_state_nxt = ST_END;
          w_cnt_nxt   = '0;
        end else if (r_cnt != ON_LAST) begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      ST_WAIT: begin
        // cnt is 0 on the first WAIT cycle, so leaving when cnt+1 reaches
        // MIN_OFF gives exactly MIN_OFF cycles of lockout.
        if ((int'(r_cnt) + 1) >= MIN_OFF) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_heating = (r_state == ST_HEAT);
  assign o_cooling = (r_state == ST_COOL);
  assign o_lockout = (r_state == ST_WAIT);

endmodule

// File: rtl/ac_ctrl_multi.sv
// ---------------------------------------------------------------------------
// ac_ctrl_multi
// Multi-zone air-conditioning controller: NUM_ZONES independent ac_zone
// instances sharing the global mode select.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ac_ctrl_multi_if slave
//              in  mode, temp
//              out heating, cooling, lockout, any_active
// ---------------------------------------------------------------------------
module ac_ctrl_multi
  import ac_pkg::*;
#(
  parameter int NUM_ZONES = 4,
  parameter int TEMP_W    = 5,
  parameter int COOL_ON   = 22,
  parameter int COOL_OFF  = 20,
  parameter int HEAT_ON   = 18,
  parameter int HEAT_OFF  = 20,
  parameter int MIN_ON    = 4,
  parameter int MIN_OFF   = 2
) (
  input logic          clk,
  input logic          rst,
  ac_ctrl_multi_if.slave bus
);

  if (NUM_ZONES < 1) begin : g_bad_zones
    $error("ac_ctrl_multi: NUM_ZONES must be at least 1");
  end

  logic                 w_heat_en;
  logic                 w_cool_en;
  logic [NUM_ZONES-1:0] w_heating;
  logic [NUM_ZONES-1:0] w_cooling;
  logic [NUM_ZONES-1:0] w_lockout;

  assign w_heat_en = |(bus.mode & MODE_HEAT);
  assign w_cool_en = |(bus.mode & MODE_COOL);

  for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
    ac_zone #(
      .TEMP_W   (TEMP_W),
      .COOL_ON  (COOL_ON),
      .COOL_OFF (COOL_OFF),
      .HEAT_ON  (HEAT_ON),
      .HEAT_OFF (HEAT_OFF),
      .MIN_ON   (MIN_ON),
      .MIN_OFF  (MIN_OFF)
    ) u_zone (
      .clk       (clk),
      .rst       (rst),
      .i_heat_en (w_heat_en),
      .i_cool_en (w_cool_en),
      .i_temp    (bus.temp[gi*TEMP_W +: TEMP_W]),
      .o_heating (w_heating[gi]),
      .o_cooling (w_cooling[gi]),
      .o_lockout (w_lockout[gi])
    );
  end

  assign bus.heating    = w_heating;
  assign bus.cooling    = w_cooling;
  assign bus.lockout    = w_lockout;
  assign bus.any_active = |(w_heating | w_cooling);

endmodule
